// File: rtl/mul_seq_fx_pkg.sv
// Shared definitions for the sequential fixed-point multiplier.
// Holds the FSM state encoding and parameter defaults and legal ranges.
package mul_seq_fx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CALC  = 2'd1,
      ST_FINAL = 2'd2
   } state_t;

   localparam int W_DEFAULT     = 12;
   localparam int W_MIN         = 4;
   localparam int W_MAX         = 32;
   localparam int FRAC_DEFAULT  = 10;
   localparam int FRAC_MIN      = 0;
   localparam int ROUND_DEFAULT = 1;

endpackage

// File: rtl/mul_seq_fx_round_sat.sv
// Combinational post-processing: rounds and shifts the magnitude product,
// re-applies the sign and saturates to W bits (fx_round_sat).
module fx_round_sat #(
   parameter int W     = 12,
   parameter int FRAC  = 10,
   parameter int ROUND = 1
) (
   input  logic [2*W-1:0] acc,
   input  logic           sign,
   input  logic           signed_en,
   output logic [W-1:0]   yout,
   output logic           ovf
);

   // One spare bit so the rounding constant cannot wrap a full-scale product.
   localparam logic [2*W:0] RND_C =
      (ROUND != 0 && FRAC > 0) ? ((2*W+1)'(1) << ((FRAC > 0) ? FRAC - 1 : 0)) : '0;
   localparam logic [2*W:0] HALF_C = (2*W+1)'(1) << (W - 1);

   logic [2*W:0] w_sum;
   logic [2*W:0] w_m;

   assign w_sum = {1'b0, acc} + RND_C;
   assign w_m   = w_sum >> FRAC;

   always_comb begin
      yout = w_m[W-1:0];
      ovf  = 1'b0;
      if (!signed_en) begin
         if (|w_m[2*W:W]) begin
            yout = {W{1'b1}};
            ovf  = 1'b1;
         end
      end else if (!sign) begin
         if (|w_m[2*W:W-1]) begin
            yout = {1'b0, {(W-1){1'b1}}};
            ovf  = 1'b1;
         end
      end else begin
         // A magnitude of exactly 2^(W-1) is the representable minimum.
         if (w_m > HALF_C) begin
            yout = {1'b1, {(W-1){1'b0}}};
            ovf  = 1'b1;
         end else begin
            yout = ~w_m[W-1:0] + W'(1);
         end
      end
   end

endmodule

// File: rtl/mul_seq_fx.sv
// Sequential shift-add fixed-point multiplier: one partial product per cycle,
// then a rounding/saturation step; result held until the next done pulse.
module mul_seq_fx
   import mul_seq_fx_pkg::*;
#(
   parameter int W     = W_DEFAULT,
   parameter int FRAC  = FRAC_DEFAULT,
   parameter int ROUND = ROUND_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         signed_en,
   input  logic [W-1:0] ain,
   input  logic [W-1:0] bin,
   output logic [W-1:0] yout,
   output logic         done,
   output logic         busy,
   output logic         ovf,
   output state_t       state_dbg
);

   localparam int CW = $clog2(W + 1);

   state_t          r_state;
   logic [W-1:0]    r_a;
   logic [2*W-1:0]  r_bsh;
   logic [2*W-1:0]  r_acc;
   logic [CW-1:0]   r_cnt;
   logic            r_neg;
   logic            r_sen;
   logic [W-1:0]    r_yout;
   logic            r_done;
   logic            r_busy;
   logic            r_ovf;

   logic            w_a_neg;
   logic            w_b_neg;
   logic [W-1:0]    w_a_mag;
   logic [W-1:0]    w_b_mag;
   logic [W-1:0]    w_y;
   logic            w_ovf;

   // Magnitudes fit in W unsigned bits, including 2^(W-1) from the minimum.
   assign w_a_neg = signed_en & ain[W-1];
   assign w_b_neg = signed_en & bin[W-1];
   assign w_a_mag = w_a_neg ? (~ain + W'(1)) : ain;
   assign w_b_mag = w_b_neg ? (~bin + W'(1)) : bin;

   fx_round_sat #(
      .W     (W),
      .FRAC  (FRAC),
      .ROUND (ROUND)
   ) u_round_sat (
      .acc       (r_acc),
      .sign      (r_neg),
      .signed_en (r_sen),
      .yout      (w_y),
      .ovf       (w_ovf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_a     <= '0;
         r_bsh   <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_neg   <= 1'b0;
         r_sen   <= 1'b0;
         r_yout  <= '0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_a     <= w_a_mag;
                  r_bsh   <= {{W{1'b0}}, w_b_mag};
                  r_neg   <= w_a_neg ^ w_b_neg;
                  r_sen   <= signed_en;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_CALC;
               end
            end
            ST_CALC: begin
               // r_a shifts right so bit 0 is always the current multiplier bit.
               if (r_a[0]) begin
                  r_acc <= r_acc + r_bsh;
               end
               r_a   <= r_a >> 1;
               r_bsh <= r_bsh << 1;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == CW'(W - 1)) begin
                  r_state <= ST_FINAL;
               end
            end
            ST_FINAL: begin
               r_yout  <= w_y;
               r_ovf   <= w_ovf;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign yout      = r_yout;
   assign done      = r_done;
   assign busy      = r_busy;
   assign ovf       = r_ovf;
   assign state_dbg = r_state;

endmodule
